// File: rtl/cpu_fetch.sv
// cpu_fetch: single-outstanding instruction fetch stage.
// Translates the PC through the ITLB, issues one memory request at a time,
// and hands instructions to decode. If decode is stalled when a response
// arrives, the response is buffered. Wrong-path responses are discarded.
// An ITLB miss is reported as an exception marker that flows down the pipe.
module cpu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_1000,
  parameter logic [31:0] EXC_PC   = 32'h0000_2000,
  parameter int          PADDR_W  = 20
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               stall,
  input  logic               jump,
  input  logic [31:0]        jump_pc,
  output logic [31:0]        itlb_vaddr,
  input  logic               itlb_hit,
  input  logic [PADDR_W-1:0] itlb_paddr,
  output logic               imem_req,
  output logic [PADDR_W-1:0] imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        instr,
  output logic               valid_instr,
  output logic [31:0]        next_pc,
  output logic               tlb_exc_raise,
  output logic [31:0]        tlb_exc_pc,
  output logic [31:0]        tlb_exc_vaddr
);

  // REQ: may issue, WAIT: one request in flight, HOLD: word parked while
  // decode stalls, DROP: in-flight response belongs to a squashed path.
  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2,
    ST_DROP = 2'd3
  } state_t;

  // Sequential PC step; 32-bit modulo, so 0xFFFF_FFFC wraps to 0.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  state_t      state_r,       state_s;
  logic [31:0] pc_r,          pc_s;
  logic [31:0] buf_data_r,    buf_data_s;
  logic [31:0] buf_pc_r,      buf_pc_s;
  logic [31:0] instr_r,       instr_s;
  logic        valid_r,       valid_s;
  logic [31:0] next_pc_r,     next_pc_s;
  logic        exc_raise_r,   exc_raise_s;
  logic [31:0] exc_pc_r,      exc_pc_s;
  logic [31:0] exc_vaddr_r,   exc_vaddr_s;
  logic        redirect_s;

  // A redirect from decode only counts when decode itself is advancing.
  assign redirect_s = jump & ~stall;

  assign itlb_vaddr = pc_r;
  assign imem_addr  = itlb_paddr;
  assign imem_req   = (state_r == ST_REQ) & itlb_hit & ~redirect_s;

  assign instr         = instr_r;
  assign valid_instr   = valid_r;
  assign next_pc       = next_pc_r;
  assign tlb_exc_raise = exc_raise_r;
  assign tlb_exc_pc    = exc_pc_r;
  assign tlb_exc_vaddr = exc_vaddr_r;

  // Next-state, next-PC and decode-register update for every fetch state.
  always_comb begin
    state_s     = state_r;
    pc_s        = pc_r;
    buf_data_s  = buf_data_r;
    buf_pc_s    = buf_pc_r;
    instr_s     = instr_r;
    next_pc_s   = next_pc_r;
    exc_pc_s    = exc_pc_r;
    exc_vaddr_s = exc_vaddr_r;

    // Any advancing cycle is a bubble unless a branch below delivers a word.
    if (!stall) begin
      valid_s     = 1'b0;
      exc_raise_s = 1'b0;
    end else begin
      valid_s     = valid_r;
      exc_raise_s = exc_raise_r;
    end

    case (state_r)
      ST_REQ: begin
        if (redirect_s) begin
          pc_s = jump_pc;
        end else if (!itlb_hit) begin
          if (!stall) begin
            instr_s     = 32'h0000_0000;
            valid_s     = 1'b1;
            exc_raise_s = 1'b1;
            exc_pc_s    = pc_r;
            exc_vaddr_s = pc_r;
            pc_s        = EXC_PC;
          end else begin
            pc_s = pc_r;
          end
        end else if (imem_gnt) begin
          state_s = ST_WAIT;
        end else begin
          state_s = ST_REQ;
        end
      end

      ST_WAIT: begin
        if (redirect_s) begin
          // The redirect beats a coincident response; an absent response
          // is still owed to us, so wait it out in DROP.
          pc_s = jump_pc;
          if (imem_rvalid) begin
            state_s = ST_REQ;
          end else begin
            state_s = ST_DROP;
          end
        end else if (imem_rvalid) begin
          if (!stall) begin
            instr_s   = imem_rdata;
            valid_s   = 1'b1;
            next_pc_s = pc_plus4(pc_r);
            pc_s      = pc_plus4(pc_r);
            state_s   = ST_REQ;
          end else begin
            buf_data_s = imem_rdata;
            buf_pc_s   = pc_r;
            state_s    = ST_HOLD;
          end
        end else begin
          state_s = ST_WAIT;
        end
      end

      ST_HOLD: begin
        if (redirect_s) begin
          pc_s       = jump_pc;
          buf_data_s = 32'h0000_0000;
          buf_pc_s   = 32'h0000_0000;
          state_s    = ST_REQ;
        end else if (!stall) begin
          instr_s   = buf_data_r;
          valid_s   = 1'b1;
          next_pc_s = pc_plus4(buf_pc_r);
          pc_s      = pc_plus4(buf_pc_r);
          state_s   = ST_REQ;
        end else begin
          state_s = ST_HOLD;
        end
      end

      ST_DROP: begin
        if (redirect_s) begin
          pc_s = jump_pc;
        end else begin
          pc_s = pc_r;
        end
        // The stale response retires the outstanding request either way.
        if (imem_rvalid) begin
          state_s = ST_REQ;
        end else begin
          state_s = ST_DROP;
        end
      end

      default: begin
        state_s = ST_REQ;
      end
    endcase
  end

  // State and pipeline registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= ST_REQ;
      pc_r        <= RESET_PC;
      buf_data_r  <= 32'h0000_0000;
      buf_pc_r    <= 32'h0000_0000;
      instr_r     <= 32'h0000_0000;
      valid_r     <= 1'b0;
      next_pc_r   <= 32'h0000_0000;
      exc_raise_r <= 1'b0;
      exc_pc_r    <= 32'h0000_0000;
      exc_vaddr_r <= 32'h0000_0000;
    end else begin
      state_r     <= state_s;
      pc_r        <= pc_s;
      buf_data_r  <= buf_data_s;
      buf_pc_r    <= buf_pc_s;
      instr_r     <= instr_s;
      valid_r     <= valid_s;
      next_pc_r   <= next_pc_s;
      exc_raise_r <= exc_raise_s;
      exc_pc_r    <= exc_pc_s;
      exc_vaddr_r <= exc_vaddr_s;
    end
  end

endmodule

// File: tb/tb_cpu_fetch.sv
// tb_cpu_fetch: directed scenarios followed by a randomized run, all checked
// against a transaction-level reference model of the fetch stage.
module tb_cpu_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_1000;
  localparam logic [31:0] EXC_PC = 32'h0000_2000;

  logic        clock = 1'b0;
  logic        reset, stall, jump, itlb_hit, imem_gnt, imem_rvalid;
  logic [31:0] jump_pc, imem_rdata;
  logic [19:0] itlb_paddr, imem_addr;
  logic [31:0] itlb_vaddr, instr, next_pc, tlb_exc_pc, tlb_exc_vaddr;
  logic        imem_req, valid_instr, tlb_exc_raise;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: PC, "a request is owed to us", "owed response is stale",
  // a queue holding a parked word, and the expected decode-side registers.
  typedef struct {
    logic [31:0] w;
    logic [31:0] pc;
  } ent_t;
  ent_t        hold_q[$];
  logic [31:0] m_pc;
  bit          m_out, m_stale, exp_req;
  logic [31:0] e_instr, e_next, e_epc, e_evaddr;
  bit          e_valid, e_raise;

  // Memory-side stimulus state.
  bit          mem_pending;
  int          mem_wait;
  logic [19:0] mem_addr;
  int          gnt_mode;   // 0: never, 1: always, 2: random
  int          rv_lat;     // extra response cycles; negative means random
  bit          spur_rvalid, rd_force_en, chk_en;
  logic [31:0] rd_force;

  cpu_fetch dut (
    .clock(clock), .reset(reset), .stall(stall), .jump(jump), .jump_pc(jump_pc),
    .itlb_vaddr(itlb_vaddr), .itlb_hit(itlb_hit), .itlb_paddr(itlb_paddr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr(instr),
    .valid_instr(valid_instr), .next_pc(next_pc), .tlb_exc_raise(tlb_exc_raise),
    .tlb_exc_pc(tlb_exc_pc), .tlb_exc_vaddr(tlb_exc_vaddr)
  );

  assign itlb_paddr = itlb_vaddr[19:0];

  always #5 clock = ~clock;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic deliver(input logic [31:0] w, input logic [31:0] pc);
    e_instr = w;
    e_valid = 1'b1;
    e_next  = pc + 32'd4;
    m_pc    = pc + 32'd4;
  endtask

  // Drive memory inputs, let combinational paths settle, compare everything.
  task automatic settle();
    imem_gnt    = (gnt_mode == 2) ? 1'($urandom_range(0, 1)) : (gnt_mode == 1);
    imem_rvalid = (mem_pending && mem_wait == 0) || spur_rvalid;
    imem_rdata  = rd_force_en ? rd_force : {12'hA5C, mem_addr};
    #2;
    exp_req = !m_out && hold_q.size() == 0 && itlb_hit && !(jump && !stall);
    if (chk_en) begin
      chk32("itlb_vaddr", itlb_vaddr, m_pc);
      chk1 ("imem_req", imem_req, exp_req);
      chk32("imem_addr", {12'h000, imem_addr}, {12'h000, m_pc[19:0]});
      chk32("instr", instr, e_instr);
      chk1 ("valid_instr", valid_instr, e_valid);
      chk32("next_pc", next_pc, e_next);
      chk1 ("tlb_exc_raise", tlb_exc_raise, e_raise);
      chk32("tlb_exc_pc", tlb_exc_pc, e_epc);
      chk32("tlb_exc_vaddr", tlb_exc_vaddr, e_evaddr);
    end
  endtask

  // Advance one clock and apply the fetch rules to the model.
  task automatic tick();
    bit acc, redir;
    ent_t ent;
    @(posedge clock);
    acc   = exp_req && imem_gnt;
    redir = jump && !stall;
    if (reset) begin
      mem_pending = 1'b0;
    end else begin
      if (mem_pending) begin
        if (mem_wait == 0) mem_pending = 1'b0;
        else mem_wait--;
      end
      if (acc) begin
        mem_pending = 1'b1;
        mem_addr    = m_pc[19:0];
        mem_wait    = (rv_lat < 0) ? int'($urandom_range(0, 2)) : rv_lat;
      end
    end
    if (reset) begin
      m_pc = RST_PC; m_out = 1'b0; m_stale = 1'b0; hold_q.delete();
      e_instr = '0; e_valid = 1'b0; e_next = '0; e_raise = 1'b0; e_epc = '0; e_evaddr = '0;
    end else begin
      if (!stall) begin
        e_valid = 1'b0;
        e_raise = 1'b0;
      end
      if (hold_q.size() != 0) begin
        if (redir) begin
          hold_q.delete();
          m_pc = jump_pc;
        end else if (!stall) begin
          ent = hold_q.pop_front();
          deliver(ent.w, ent.pc);
        end
      end else if (m_out) begin
        if (imem_rvalid) begin
          m_out = 1'b0;
          if (redir) m_pc = jump_pc;
          else if (!m_stale) begin
            if (!stall) deliver(imem_rdata, m_pc);
            else hold_q.push_back('{imem_rdata, m_pc});
          end
          m_stale = 1'b0;
        end else if (redir) begin
          m_stale = 1'b1;
          m_pc    = jump_pc;
        end
      end else begin
        if (redir) m_pc = jump_pc;
        else if (!itlb_hit) begin
          if (!stall) begin
            e_instr = 32'h0; e_valid = 1'b1; e_raise = 1'b1;
            e_epc = m_pc; e_evaddr = m_pc; m_pc = EXC_PC;
          end
        end else if (imem_gnt) m_out = 1'b1;
      end
    end
    #1;
  endtask

  initial begin
    bit seen;
    reset = 1'b1; stall = 1'b0; jump = 1'b0; jump_pc = '0; itlb_hit = 1'b1;
    gnt_mode = 1; rv_lat = 0; spur_rvalid = 1'b0; rd_force_en = 1'b0; rd_force = '0;
    mem_pending = 1'b0; mem_wait = 0; mem_addr = '0; chk_en = 1'b0;
    m_pc = RST_PC; m_out = 1'b0; m_stale = 1'b0; exp_req = 1'b0;
    e_instr = '0; e_valid = 1'b0; e_next = '0; e_raise = 1'b0; e_epc = '0; e_evaddr = '0;
    #1;
    settle(); tick();
    chk_en = 1'b1;

    // Reset state.
    settle();
    chk32("rst_vaddr", itlb_vaddr, 32'h0000_1000);
    chk1 ("rst_valid", valid_instr, 1'b0);
    chk32("rst_instr", instr, 32'h0);
    chk32("rst_next_pc", next_pc, 32'h0);
    chk1 ("rst_exc", tlb_exc_raise, 1'b0);
    tick();
    reset = 1'b0;

    // Basic fetch.
    settle();
    chk32("first_addr", {12'h0, imem_addr}, 32'h0000_1000);
    chk1 ("first_req", imem_req, 1'b1);
    tick();
    settle(); tick();
    settle();
    chk32("first_instr", instr, 32'hA5C0_1000);
    chk1 ("first_valid", valid_instr, 1'b1);
    chk32("first_next_pc", next_pc, 32'h0000_1004);
    chk32("second_addr", {12'h0, imem_addr}, 32'h0000_1004);
    tick();

    // Response under stall is parked, then released.
    rd_force_en = 1'b1; rd_force = 32'hDEAD_BEEF; stall = 1'b1;
    settle(); tick();
    for (int i = 0; i < 2; i++) begin
      settle();
      chk32("hold_instr", instr, 32'hA5C0_1000);
      chk1 ("hold_req", imem_req, 1'b0);
      tick();
    end
    stall = 1'b0; rd_force_en = 1'b0; itlb_hit = 1'b0;
    settle(); tick();
    settle();
    chk32("release_instr", instr, 32'hDEAD_BEEF);
    chk1 ("release_valid", valid_instr, 1'b1);
    chk1 ("miss_no_req", imem_req, 1'b0);
    tick();

    // ITLB miss at 0x1008.
    itlb_hit = 1'b1;
    settle();
    chk1 ("miss_raise", tlb_exc_raise, 1'b1);
    chk32("miss_pc", tlb_exc_pc, 32'h0000_1008);
    chk32("miss_vaddr", tlb_exc_vaddr, 32'h0000_1008);
    chk1 ("miss_valid", valid_instr, 1'b1);
    chk32("miss_instr", instr, 32'h0);
    chk32("miss_next_addr", {12'h0, imem_addr}, 32'h0000_2000);
    rv_lat = 3;
    tick();

    // Redirect while a request is in flight.
    jump = 1'b1; jump_pc = 32'h0000_3000;
    settle(); tick();
    jump = 1'b0; rv_lat = 0; seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      settle();
      chk1 ("drop_valid", valid_instr, 1'b0);
      chk32("drop_instr", instr, 32'h0);
      seen = imem_rvalid;
      tick();
    end
    chk1("drop_rvalid_seen", seen, 1'b1);
    settle();
    chk32("redirect_addr", {12'h0, imem_addr}, 32'h0000_3000);
    chk1 ("redirect_valid", valid_instr, 1'b0);
    tick();
    settle(); tick();
    gnt_mode = 0;
    settle();
    chk32("redirect_instr", instr, 32'hA5C0_3000);
    tick();

    // Grant withheld for five cycles.
    for (int i = 0; i < 5; i++) begin
      settle();
      chk1 ("nognt_req", imem_req, 1'b1);
      chk32("nognt_addr", {12'h0, imem_addr}, 32'h0000_3004);
      chk1 ("nognt_valid", valid_instr, 1'b0);
      tick();
    end
    gnt_mode = 1;
    settle(); tick();
    settle(); tick();
    settle();
    chk32("resume_instr", instr, 32'hA5C0_3004);
    tick();

    // Jump coincident with response, then reset during a new request.
    jump = 1'b1; jump_pc = 32'h0000_4000;
    settle(); tick();
    jump = 1'b0; rv_lat = 2;
    settle();
    chk32("coinc_pc", itlb_vaddr, 32'h0000_4000);
    chk1 ("coinc_valid", valid_instr, 1'b0);
    tick();
    settle(); tick();
    reset = 1'b1;
    settle(); tick();
    reset = 1'b0; gnt_mode = 0; spur_rvalid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk32("post_rst_pc", itlb_vaddr, 32'h0000_1000);
      tick();
    end
    spur_rvalid = 1'b0; gnt_mode = 1; rv_lat = 0;
    settle(); tick();
    settle(); tick();
    jump = 1'b1; jump_pc = 32'hFFFF_FFFC;
    settle();
    chk32("restart_instr", instr, 32'hA5C0_1000);
    chk32("restart_next", next_pc, 32'h0000_1004);
    tick();

    // PC wrap-around.
    jump = 1'b0;
    settle(); tick();
    settle(); tick();
    settle();
    chk32("wrap_next_pc", next_pc, 32'h0);
    chk32("wrap_vaddr", itlb_vaddr, 32'h0);
    tick();

    // Randomized traffic.
    gnt_mode = 2; rv_lat = -1; rd_force_en = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      stall    = ($urandom_range(0, 3) == 0);
      jump     = ($urandom_range(0, 11) == 0);
      jump_pc  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
      itlb_hit = ($urandom_range(0, 9) != 0);
      reset    = ($urandom_range(0, 99) == 0);
      rd_force = $urandom;
      settle();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cpu_fetch.md
CPU_FETCH -- requirements
Module: cpu_fetch

Interface
REQ-001 Parameters: RESET_PC, default 32'h0000_1000, first fetch address after reset; EXC_PC, default 32'h0000_2000, ITLB-miss handler address; PADDR_W, default 20, physical address width.
REQ-002 clock  in  1  core clock; reset is sampled on its rising edge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 stall  in  1  decode stall; decode-side registers shall hold.
REQ-005 jump  in  1  redirect request from decode.
REQ-006 jump_pc  in  32  redirect target.
REQ-007 itlb_vaddr  out  32  current PC, presented to the ITLB.
REQ-008 itlb_hit  in  1  combinational ITLB hit.
REQ-009 itlb_paddr  in  PADDR_W  combinational translation.
REQ-010 imem_req  out  1  instruction memory request valid.
REQ-011 imem_addr  out  PADDR_W  request physical address.
REQ-012 imem_gnt  in  1  request accepted this cycle.
REQ-013 imem_rvalid  in  1  response valid; arrives at least 1 cycle after imem_gnt.
REQ-014 imem_rdata  in  32  instruction word.
REQ-015 instr  out  32  registered instruction to decode.
REQ-016 valid_instr  out  1  instr is valid.
REQ-017 next_pc  out  32  PC of instr + 4.
REQ-018 tlb_exc_raise  out  1  ITLB-miss marker.
REQ-019 tlb_exc_pc  out  32  faulting PC.
REQ-020 tlb_exc_vaddr  out  32  faulting virtual address.

Function
REQ-021 States: REQ (issue), WAIT (one request outstanding), HOLD (word buffered, decode stalled), DROP (discard stale response). At most one outstanding request at any time.
REQ-022 itlb_vaddr shall equal pc. imem_addr shall equal itlb_paddr. imem_req shall be 1 only when state==REQ & itlb_hit & ~(jump & ~stall).
REQ-023 Transition REQ->WAIT on imem_req & imem_gnt. Without gnt, stay in REQ with pc and imem_addr held stable.
REQ-024 WAIT with imem_rvalid & ~stall: instr<=imem_rdata, valid_instr<=1, next_pc<=pc+4, pc<=pc+4, state->REQ.
REQ-025 WAIT with imem_rvalid & stall: buffer imem_rdata and pc, state->HOLD, decode registers unchanged.
REQ-026 HOLD & ~stall: load the decode registers from the buffer, pc<=buffered pc+4, state->REQ.
REQ-027 Bubble insertion: in any cycle with ~stall and no word delivered, the block shall set valid_instr<=0 and tlb_exc_raise<=0.
REQ-028 Redirect is accepted only on jump & ~stall. Accepted redirect: pc<=jump_pc; valid_instr<=0 (wrong-path flush).
REQ-029 Redirect state effects: REQ stays REQ with the new pc; HOLD discards the buffer and goes to REQ; WAIT goes to DROP; DROP stays in DROP with the pc updated.
REQ-030 Redirect versus same-cycle imem_rvalid in WAIT: the redirect wins, the word is discarded, state->REQ.
REQ-031 DROP: on imem_rvalid, discard the word, state->REQ. No output change other than bubble rules.
REQ-032 ITLB miss (state REQ, ~itlb_hit, ~stall, no redirect): no imem_req; instr<=32'h0, valid_instr<=1, tlb_exc_raise<=1, tlb_exc_pc<=pc, tlb_exc_vaddr<=pc, pc<=EXC_PC; state stays REQ.
REQ-033 PC arithmetic is 32-bit modulo. 32'hFFFF_FFFC+4 wraps to 0. jump_pc is used unaligned as given.
REQ-034 Under stall, instr, valid_instr, next_pc and tlb_exc_* shall hold their values.

Reset
REQ-035 On reset: pc<=RESET_PC, state<=REQ, valid_instr<=0, tlb_exc_raise<=0, instr<=0, next_pc<=0, tlb_exc_pc<=0, tlb_exc_vaddr<=0, buffer cleared.
REQ-036 Reset asserted during WAIT or DROP abandons the outstanding request. After reset, any imem_rvalid received before the first post-reset imem_gnt shall be ignored.

Verification
REQ-037 Reset, itlb_hit=1, paddr=vaddr[19:0], gnt immediate, rvalid 1 cycle later -> first imem_addr=20'h01000; valid_instr=1 with instr=rdata, next_pc=32'h1004; next imem_addr=20'h01004.
REQ-038 stall=1 while rvalid arrives with 32'hDEADBEEF -> decode outputs hold and state=HOLD; stall=0 -> instr=32'hDEADBEEF, valid_instr=1 on the next edge.
REQ-039 jump=1, jump_pc=32'h3000 while in WAIT -> the in-flight response is dropped and never appears on instr; next imem_addr=20'h03000; valid_instr=0 for every cycle until that word returns.
REQ-040 itlb_hit=0 at pc=32'h1008 -> no imem_req; tlb_exc_raise=1, tlb_exc_pc=32'h1008, valid_instr=1, instr=0; next request is to 20'h02000.
REQ-041 imem_gnt held 0 for 5 cycles -> imem_req stays 1 with a stable addr and valid_instr=0 throughout; on gnt, normal flow resumes.
REQ-042 jump coincident with rvalid in WAIT, then reset asserted during a new WAIT -> the word is discarded, pc=jump_pc; after reset, fetch restarts at 32'h1000 and the stale rvalid is ignored.
